fifo_prog: RTL and testbench

Parametrised synchronous FIFO: the next generation of the team's basic `fifo`. It adds an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a choice of registered-read or first-word-fall-through (FWFT) output. It sits between any producer/consumer pair that share one clock, such as UART/SPI byte streams and packet buffers, and keeps the original enq/deq handshake naming.

---
 rtl/fifo_prog_pkg.sv | 14 +
 rtl/fifo_mem.sv | 25 ++
 rtl/fifo_prog.sv | 125 ++++++++++++
 tb/tb_fifo_prog.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fifo_prog_pkg.sv
// Shared helpers for the programmable FIFO family: width math used for
// pointer, count and memory address sizing.
package fifo_prog_pkg;

   // Ceiling log2 usable in parameter/port declarations.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Word storage for fifo_prog: synchronous write, combinational read.
module fifo_mem
   import fifo_prog_pkg::*;
#(
   parameter int p_WORD_LEN  = 8,
   parameter int p_FIFO_SIZE = 8
) (
   input  logic                            i_clk,
   input  logic                            i_we,
   input  logic [clog2(p_FIFO_SIZE)-1:0]   i_waddr,
   input  logic [p_WORD_LEN-1:0]           i_wdata,
   input  logic [clog2(p_FIFO_SIZE)-1:0]   i_raddr,
   output logic [p_WORD_LEN-1:0]           o_rdata
);

   logic [p_WORD_LEN-1:0] mem_q [p_FIFO_SIZE];

   // No reset: contents are only meaningful between the pointers.
   always_ff @(posedge i_clk) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT.
module fifo_prog
   import fifo_prog_pkg::*;
#(
   parameter int p_WORD_LEN      = 8,
   parameter int p_FIFO_SIZE     = 8,
   parameter int p_FWFT          = 0,
   parameter int p_AFULL_THRESH  = 6,
   parameter int p_AEMPTY_THRESH = 2
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_flush,
   input  logic [p_WORD_LEN-1:0]         i_enq_data,
   input  logic                          i_enq_en,
   output logic                          o_enq_rdy,
   output logic [p_WORD_LEN-1:0]         o_out_data,
   input  logic                          i_deq_en,
   output logic                          o_deq_rdy,
   output logic                          o_full,
   output logic                          o_empty,
   output logic                          o_almost_full,
   output logic                          o_almost_empty,
   output logic [clog2(p_FIFO_SIZE):0]   o_count,
   output logic                          o_overflow,
   output logic                          o_underflow
);

   localparam int AW = clog2(p_FIFO_SIZE);
   localparam int CW = AW + 1;

   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic [CW-1:0]         count;
   logic                  full, empty;
   logic                  enq_acc, deq_acc;
   logic [p_WORD_LEN-1:0] mem_rdata;

   // Flags are decoded from the pointer registers only, so o_enq_rdy has
   // no combinational dependence on i_deq_en.
   assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign enq_acc = i_enq_en & ~full;
   assign deq_acc = i_deq_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (enq_acc) wr_ptr_d = wr_ptr_q + CW'(1);
         if (deq_acc) rd_ptr_d = rd_ptr_q + CW'(1);
         if (i_enq_en & full)  ovf_d = 1'b1;
         if (i_deq_en & empty) udf_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_mem #(
      .p_WORD_LEN  (p_WORD_LEN),
      .p_FIFO_SIZE (p_FIFO_SIZE)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (enq_acc & ~i_flush),
      .i_waddr (wr_ptr_q[AW-1:0]),
      .i_wdata (i_enq_data),
      .i_raddr (rd_ptr_q[AW-1:0]),
      .o_rdata (mem_rdata)
   );

   generate
      if (p_FWFT != 0) begin : g_fwft
         assign o_out_data = mem_rdata;
      end else begin : g_reg
         logic [p_WORD_LEN-1:0] dout_q, dout_d;

         always_comb begin
            dout_d = dout_q;
            if (i_flush)      dout_d = '0;
            else if (deq_acc) dout_d = mem_rdata;
         end

         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) dout_q <= '0;
            else         dout_q <= dout_d;
         end

         assign o_out_data = dout_q;
      end
   endgenerate

   assign o_full         = full;
   assign o_empty        = empty;
   assign o_enq_rdy      = ~full;
   assign o_deq_rdy      = ~empty;
   assign o_count        = count;
   assign o_almost_full  = (count >= CW'(p_AFULL_THRESH));
   assign o_almost_empty = (count <= CW'(p_AEMPTY_THRESH));
   assign o_overflow     = ovf_q;
   assign o_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_prog.sv
// Drives a registered-read and an FWFT fifo_prog with identical stimulus
// and compares both against a queue-based reference model.
module tb_fifo_prog;

   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic       i_clk = 1'b0;
   logic       i_reset, i_flush, i_enq_en, i_deq_en;
   logic [7:0] i_enq_data;

   logic       enq_rdy0, deq_rdy0, full0, empty0, af0, ae0, ovf0, udf0;
   logic [7:0] dout0;
   logic [3:0] cnt0;
   logic       enq_rdy1, deq_rdy1, full1, empty1, af1, ae1, ovf1, udf1;
   logic [7:0] dout1;
   logic [3:0] cnt1;

   int n_checks = 0;
   int n_errors = 0;

   // reference model
   logic [7:0] mq[$];
   logic       m_ovf, m_udf;
   logic [7:0] m_dout;

   always #5 i_clk = ~i_clk;

   fifo_prog #(.p_WORD_LEN(8), .p_FIFO_SIZE(DEPTH), .p_FWFT(0),
               .p_AFULL_THRESH(AF), .p_AEMPTY_THRESH(AE)) dut0 (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_enq_data(i_enq_data), .i_enq_en(i_enq_en), .o_enq_rdy(enq_rdy0),
      .o_out_data(dout0), .i_deq_en(i_deq_en), .o_deq_rdy(deq_rdy0),
      .o_full(full0), .o_empty(empty0), .o_almost_full(af0),
      .o_almost_empty(ae0), .o_count(cnt0), .o_overflow(ovf0),
      .o_underflow(udf0));

   fifo_prog #(.p_WORD_LEN(8), .p_FIFO_SIZE(DEPTH), .p_FWFT(1),
               .p_AFULL_THRESH(AF), .p_AEMPTY_THRESH(AE)) dut1 (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_enq_data(i_enq_data), .i_enq_en(i_enq_en), .o_enq_rdy(enq_rdy1),
      .o_out_data(dout1), .i_deq_en(i_deq_en), .o_deq_rdy(deq_rdy1),
      .o_full(full1), .o_empty(empty1), .o_almost_full(af1),
      .o_almost_empty(ae1), .o_count(cnt1), .o_overflow(ovf1),
      .o_underflow(udf1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = mq.size();
      chk("count0",  32'(cnt0),     32'(n));
      chk("count1",  32'(cnt1),     32'(n));
      chk("full0",   32'(full0),    32'(n == DEPTH));
      chk("full1",   32'(full1),    32'(n == DEPTH));
      chk("empty0",  32'(empty0),   32'(n == 0));
      chk("empty1",  32'(empty1),   32'(n == 0));
      chk("enqrdy0", 32'(enq_rdy0), 32'(n != DEPTH));
      chk("enqrdy1", 32'(enq_rdy1), 32'(n != DEPTH));
      chk("deqrdy0", 32'(deq_rdy0), 32'(n != 0));
      chk("deqrdy1", 32'(deq_rdy1), 32'(n != 0));
      chk("afull0",  32'(af0),      32'(n >= AF));
      chk("afull1",  32'(af1),      32'(n >= AF));
      chk("aempty0", 32'(ae0),      32'(n <= AE));
      chk("aempty1", 32'(ae1),      32'(n <= AE));
      chk("ovf0",    32'(ovf0),     32'(m_ovf));
      chk("ovf1",    32'(ovf1),     32'(m_ovf));
      chk("udf0",    32'(udf0),     32'(m_udf));
      chk("udf1",    32'(udf1),     32'(m_udf));
      chk("dout0",   32'(dout0),    32'(m_dout));
      if (n != 0) chk("dout1", 32'(dout1), 32'(mq[0]));
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = 8'h00;
   endtask

   // One clock: apply inputs, advance model on the edge, check 1 time unit later.
   task automatic step(input logic enq, input logic [7:0] data, input logic deq, input logic flush);
      int  n;
      logic [7:0] w;
      i_enq_en   = enq;
      i_enq_data = data;
      i_deq_en   = deq;
      i_flush    = flush;
      @(posedge i_clk);
      n = mq.size();
      if (flush) begin
         model_reset();
      end else begin
         if (enq && n == DEPTH) m_ovf = 1'b1;
         if (deq && n == 0)     m_udf = 1'b1;
         if (deq && n != 0) begin
            w = mq.pop_front();
            m_dout = w;
         end
         if (enq && n != DEPTH) mq.push_back(data);
      end
      #1;
      check_all();
   endtask

   initial begin
      i_reset = 1'b1; i_flush = 1'b0; i_enq_en = 1'b0; i_deq_en = 1'b0; i_enq_data = '0;
      model_reset();
      #12;
      check_all();
      @(negedge i_clk);
      i_reset = 1'b0;

      // fill 0x11..0x88, then overflow with 0x99
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b0);
      // enq+deq while full: enq still dropped
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      // underflow on empty, also with simultaneous enq
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // steady state at count 4 across pointer wrap
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      for (int i = 4; i < 24; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);

      // async reset mid-burst at count 5
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      i_enq_en = 1'b1; i_deq_en = 1'b1; i_enq_data = 8'hEE;
      #2;
      i_reset = 1'b1;
      model_reset();
      #1;
      check_all();
      #1;
      i_reset = 1'b0;

      // flush together with enq drops the word
      step(1'b1, 8'h31, 1'b0, 1'b0);
      step(1'b1, 8'h32, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 50),
              1'($urandom_range(0, 63) == 0));
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 99) < 25), 8'($urandom), 1'($urandom_range(0, 99) < 80), 1'b0);
      for (int i = 0; i < 60; i++)
         step(1'($urandom_range(0, 99) < 85), 8'($urandom), 1'($urandom_range(0, 99) < 20), 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
